// File: rtl/memory_access_unit.sv
// Memory stage bus master: single scalar byte or four-beat 128-bit vector accesses over a 32-bit bus.
// Optional bus-timeout watchdog is enabled by defining MEM_ACCESS_TIMEOUT_EN.
module memory_access_unit (
  input  logic         clk,
  input  logic         reset,
  input  logic         write_memory_enable_memory,
  input  logic         select_writeback_data_mux_memory,
  input  logic         vector_op_memory,
  input  logic [7:0]   ALUresult_memory,
  input  logic [7:0]   srcB_memory,
  input  logic [11:0]  vector_address_data_memory,
  input  logic [127:0] vector_data_memory,
  output logic         stall_memory,
  output logic         mem_req,
  output logic         mem_we,
  output logic [11:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ready,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic [7:0]   load_data_scalar,
  output logic [127:0] load_data_vector,
  output logic         load_valid,
  output logic         mem_error
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  beat_reg;
  logic        load_op_reg;
  logic        access, is_store, in_req, last_beat;
  logic        store_accept, read_accept, read_done;
  logic        timeout_hit, abort_flag;
  logic [11:0] vec_base, vec_addr;

  assign access       = write_memory_enable_memory | select_writeback_data_mux_memory;
  assign is_store     = write_memory_enable_memory;
  assign in_req       = (state_reg == REQ);
  assign last_beat    = !vector_op_memory || (beat_reg == 2'd3);
  assign store_accept = in_req && mem_ready && is_store;
  assign read_accept  = in_req && mem_ready && !is_store;
  assign read_done    = (state_reg == WAIT_RD) && mem_rvalid;

  // Masking keeps the full input in use; the 12-bit add wraps 0xFFC -> 0x000 for free.
  assign vec_base = vector_address_data_memory & 12'hFFC;
  assign vec_addr = vec_base + {8'd0, beat_reg, 2'b00};

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0] wdog_reg;
  logic       err_reg, abort_reg, waiting;

  assign waiting     = (in_req && !mem_ready) || ((state_reg == WAIT_RD) && !mem_rvalid);
  assign timeout_hit = waiting && (wdog_reg == 8'd254);
  assign abort_flag  = abort_reg;
  assign mem_error   = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_reg  <= 8'd0;
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      wdog_reg <= waiting ? wdog_reg + 8'd1 : 8'd0;
      if (timeout_hit)
        err_reg <= 1'b1;
      if (state_reg == IDLE)
        abort_reg <= 1'b0;
      else if (timeout_hit)
        abort_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign abort_flag  = 1'b0;
  assign mem_error   = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (access) state_next = REQ;
      REQ: begin
        if (store_accept)     state_next = last_beat ? DONE : REQ;
        else if (read_accept) state_next = WAIT_RD;
      end
      WAIT_RD: if (mem_rvalid) state_next = last_beat ? DONE : REQ;
      default: state_next = IDLE;
    endcase
    if (timeout_hit)
      state_next = DONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      beat_reg    <= 2'd0;
      load_op_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE) begin
        beat_reg    <= 2'd0;
        load_op_reg <= !write_memory_enable_memory && select_writeback_data_mux_memory;
      end else if (store_accept || read_done) begin
        beat_reg <= beat_reg + 2'd1;
      end
    end
  end

  // Bus outputs are derived from frozen pipeline inputs, so they stay stable while REQ waits.
  always_comb begin
    mem_req   = in_req;
    mem_we    = in_req && is_store;
    mem_addr  = 12'd0;
    mem_be    = 4'd0;
    mem_wdata = 32'd0;
    if (in_req) begin
      if (vector_op_memory) begin
        mem_addr  = vec_addr;
        mem_be    = 4'hF;
        mem_wdata = vector_data_memory[{beat_reg, 5'b00000} +: 32];
      end else begin
        mem_addr  = {4'b0000, ALUresult_memory[7:2], 2'b00};
        mem_be    = 4'b0001 << ALUresult_memory[1:0];
        mem_wdata = {4{srcB_memory}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      load_data_scalar <= 8'd0;
    else if (read_done && !vector_op_memory)
      load_data_scalar <= mem_rdata[{ALUresult_memory[1:0], 3'b000} +: 8];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          load_data_vector[32*gi +: 32] <= 32'd0;
        else if (read_done && vector_op_memory && (beat_reg == gi[1:0]))
          load_data_vector[32*gi +: 32] <= mem_rdata;
      end
    end
  endgenerate

  assign load_valid   = (state_reg == DONE) && load_op_reg && !abort_flag;
  assign stall_memory = access && (state_reg != DONE);

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: bus responder, beat logger and hand-computed expectations.
// Define MEM_ACCESS_TIMEOUT_EN for both files to also exercise the watchdog.
module tb_memory_access_unit;
  logic         clk = 1'b0;
  logic         reset;
  logic         we_in, sel_in, vec_in;
  logic [7:0]   alu_in, srcb_in;
  logic [11:0]  vaddr_in;
  logic [127:0] vdata_in;
  logic         stall_memory, mem_req, mem_we, mem_ready, mem_rvalid;
  logic [11:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic [3:0]   mem_be;
  logic [7:0]   load_data_scalar;
  logic [127:0] load_data_vector;
  logic         load_valid, mem_error;

  always #5 clk = ~clk;

  memory_access_unit dut (
    .clk(clk), .reset(reset),
    .write_memory_enable_memory(we_in), .select_writeback_data_mux_memory(sel_in),
    .vector_op_memory(vec_in), .ALUresult_memory(alu_in), .srcB_memory(srcb_in),
    .vector_address_data_memory(vaddr_in), .vector_data_memory(vdata_in),
    .stall_memory(stall_memory), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .load_data_scalar(load_data_scalar), .load_data_vector(load_data_vector),
    .load_valid(load_valid), .mem_error(mem_error)
  );

  int nchk = 0, nerr = 0;
  int nstall, nlv, nbeat, rd_idx;
  logic [11:0] log_addr[8];
  logic [31:0] log_wd[8];
  logic [3:0]  log_be[8];
  logic        log_we[8];
  logic [31:0] rd_data[4];
  logic        last_stall, last_req;
  logic [11:0] last_addr;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample at negedge, then drive the responder 1ns after posedge.
  task automatic cycle();
    logic acc;
    @(negedge clk);
    last_stall = stall_memory;
    last_req   = mem_req;
    last_addr  = mem_addr;
    if (stall_memory) nstall++;
    if (load_valid) nlv++;
    acc = mem_req && mem_ready;
    if (acc && nbeat < 8) begin
      log_addr[nbeat] = mem_addr;
      log_wd[nbeat]   = mem_wdata;
      log_be[nbeat]   = mem_be;
      log_we[nbeat]   = mem_we;
      nbeat++;
    end
    @(posedge clk);
    #1;
    mem_rvalid = acc && !mem_we;
    mem_rdata  = 32'hDEAD_BEEF;
    if (mem_rvalid && rd_idx < 4) begin
      mem_rdata = rd_data[rd_idx];
      rd_idx++;
    end
  endtask

  task automatic begin_txn();
    nstall = 0; nlv = 0; nbeat = 0; rd_idx = 0;
  endtask

  task automatic finish_txn(input string name, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      done = !last_stall;
    end
    check({name, "_completes"}, done, 1'b1);
    we_in = 1'b0; sel_in = 1'b0;
    $display("txn %s: beats=%0d stall_cycles=%0d load_valid_pulses=%0d", name, nbeat, nstall, nlv);
    cycle();
  endtask

  task automatic present(input logic we, input logic sel, input logic vec,
                         input logic [7:0] alu, input logic [7:0] srcb,
                         input logic [11:0] vaddr, input logic [127:0] vdata);
    we_in = we; sel_in = sel; vec_in = vec; alu_in = alu; srcb_in = srcb;
    vaddr_in = vaddr; vdata_in = vdata;
  endtask

  initial begin
    reset = 1'b0; mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    present(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 12'h000, 128'd0);
    begin_txn();
    repeat (2) @(posedge clk);
    #2;
    check("rst_req", mem_req, 1'b0);
    check("rst_bus", {mem_we, mem_addr, mem_wdata, mem_be}, 49'd0);
    check("rst_loads", {load_data_scalar, load_data_vector, load_valid}, 137'd0);
    check("rst_err_stall", {mem_error, stall_memory}, 2'b00);
    @(posedge clk); #1 reset = 1'b1;
    cycle();

    // Scalar store to lane 1
    begin_txn();
    present(1'b1, 1'b0, 1'b0, 8'h0D, 8'hA5, 12'h000, 128'd0);
    finish_txn("st_scalar", 20);
    check("sst_beats", nbeat, 1);
    check("sst_addr", log_addr[0], 12'h00C);
    check("sst_be", log_be[0], 4'b0010);
    check("sst_wdata", log_wd[0], 32'hA5A5A5A5);
    check("sst_we", log_we[0], 1'b1);
    check("sst_stall", nstall, 2);

    // Scalar store to lane 2, high address
    begin_txn();
    present(1'b1, 1'b0, 1'b0, 8'hF2, 8'h3C, 12'h000, 128'd0);
    finish_txn("st_scalar2", 20);
    check("sst2_addr_be", {log_addr[0], log_be[0]}, {12'h0F0, 4'b0100});
    check("sst2_wdata", log_wd[0], 32'h3C3C3C3C);

    // Vector store with unaligned base; low bits are dropped
    begin_txn();
    present(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 12'h123,
            128'h0F0E0D0C_0B0A0908_07060504_03020100);
    finish_txn("st_vector", 30);
    check("vst_beats", nbeat, 4);
    check("vst_addrs", {log_addr[0], log_addr[1], log_addr[2], log_addr[3]},
          {12'h120, 12'h124, 12'h128, 12'h12C});
    check("vst_wd0", log_wd[0], 32'h03020100);
    check("vst_wd3", log_wd[3], 32'h0F0E0D0C);
    check("vst_be", {log_be[0], log_be[3]}, 8'hFF);
    check("vst_stall", nstall, 5);

    // Vector load wrapping past 0xFFC
    begin_txn();
    rd_data[0] = 32'h11111111; rd_data[1] = 32'h22222222;
    rd_data[2] = 32'h33333333; rd_data[3] = 32'h44444444;
    present(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 12'hFF8, 128'd0);
    finish_txn("ld_vector", 40);
    check("vld_addrs", {log_addr[0], log_addr[1], log_addr[2], log_addr[3]},
          {12'hFF8, 12'hFFC, 12'h000, 12'h004});
    check("vld_we", {log_we[0], log_we[3]}, 2'b00);
    check("vld_data", load_data_vector, 128'h44444444_33333333_22222222_11111111);
    check("vld_valid_pulses", nlv, 1);
    check("vld_stall", nstall, 9);

    // Scalar load at byte 3 with ready held low for three cycles
    begin_txn();
    rd_data[0] = 32'hC3B2A190;
    mem_ready = 1'b0;
    present(1'b0, 1'b1, 1'b0, 8'h03, 8'h00, 12'h000, 128'd0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("sld_hold_req", last_req, 1'b1);
      check("sld_hold_addr", last_addr, 12'h000);
    end
    mem_ready = 1'b1;
    finish_txn("ld_scalar_wait", 20);
    check("sld_data", load_data_scalar, 8'hC3);
    check("sld_stall", nstall, 6);
    check("sld_vec_hold", load_data_vector, 128'h44444444_33333333_22222222_11111111);
    check("sld_valid_pulses", nlv, 1);

    // Scalar load at byte 1
    begin_txn();
    rd_data[0] = 32'h12345678;
    present(1'b0, 1'b1, 1'b0, 8'h41, 8'h00, 12'h000, 128'd0);
    finish_txn("ld_scalar", 20);
    check("sld2_addr_be", {log_addr[0], log_be[0]}, {12'h040, 4'b0010});
    check("sld2_data", load_data_scalar, 8'h56);
    check("sld2_stall", nstall, 3);

    // Both requests: store wins
    begin_txn();
    present(1'b1, 1'b1, 1'b0, 8'h22, 8'h77, 12'h000, 128'd0);
    finish_txn("both_req", 20);
    check("both_we", log_we[0], 1'b1);
    check("both_wdata", log_wd[0], 32'h77777777);
    check("both_no_valid", nlv, 0);
    check("both_scalar_hold", load_data_scalar, 8'h56);

    // Reset in the middle of beat 2 of a vector store
    begin_txn();
    present(1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 12'h200,
            128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    cycle(); cycle(); cycle();
    check("rst_mid_req_before", {mem_req, mem_addr}, {1'b1, 12'h208});
    reset = 1'b0;
    #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_bus", {mem_addr, mem_wdata, mem_be}, 48'd0);
    check("rst_mid_loads", {load_data_scalar, load_data_vector}, 136'd0);
    #1 reset = 1'b1;
    begin_txn();
    finish_txn("st_restart", 30);
    check("restart_beats", nbeat, 4);
    check("restart_addr0", {log_addr[0], log_wd[0]}, {12'h200, 32'hAAAAAAAA});
    check("restart_stall", nstall, 5);

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin_txn();
    mem_ready = 1'b0;
    present(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 12'h000, 128'd0);
    finish_txn("timeout", 400);
    check("to_error", mem_error, 1'b1);
    check("to_stall", nstall, 256);
    check("to_no_valid", nlv, 0);
    mem_ready = 1'b1;
`else
    check("no_error", mem_error, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous reset, active-low.
REQ-004 write_memory_enable_memory  in  1  store request from the EX/MEM stage.
REQ-005 select_writeback_data_mux_memory  in  1  load request; memory data goes to writeback.
REQ-006 vector_op_memory  in  1  access type: 1 = 128-bit vector, 0 = 8-bit scalar.
REQ-007 ALUresult_memory  in  8  scalar byte address.
REQ-008 srcB_memory  in  8  scalar store data.
REQ-009 vector_address_data_memory  in  12  vector base byte address.
REQ-010 vector_data_memory  in  128  vector store data.
REQ-011 stall_memory  out  1  freezes EX/MEM and all earlier stages.
REQ-012 mem_req, mem_we  out  1 each  bus request valid and write strobe.
REQ-013 mem_addr  out  12  word-aligned bus address; bits [1:0] SHALL always be 0.
REQ-014 mem_wdata, mem_be  out  32, 4  bus write data and byte enables.
REQ-015 mem_ready, mem_rvalid  in  1 each  request accepted and read data valid.
REQ-016 mem_rdata  in  32  bus read data.
REQ-017 load_data_scalar, load_data_vector  out  8, 128  load results.
REQ-018 load_valid  out  1  one-cycle pulse when a load completes.
REQ-019 mem_error  out  1  sticky bus-timeout flag.

Function
REQ-020 The access SHALL be a store when write_memory_enable_memory=1, a load when only select_writeback_data_mux_memory=1, and none otherwise.
- A store SHALL take priority when both request inputs are 1.
REQ-021 The FSM SHALL have four states: IDLE, REQ, WAIT_RD, DONE.
- IDLE -> REQ when an access is present.
- REQ -> DONE on store accept (last beat).
- REQ -> WAIT_RD on read accept.
- WAIT_RD -> DONE on mem_rvalid (last beat).
- REQ -> REQ on store accept (not last beat).
- WAIT_RD -> REQ on mem_rvalid (not last beat).
- DONE -> IDLE unconditionally.
REQ-022 stall_memory SHALL equal (access present AND state != DONE), computed combinationally.
REQ-023 mem_req SHALL be 1 only in REQ, and mem_addr, mem_we, mem_wdata and mem_be SHALL hold stable until mem_ready=1.
REQ-024 A scalar access SHALL use one beat with:
- mem_addr = {4'b0, ALUresult_memory[7:2], 2'b00}
- mem_be = one-hot lane ALUresult_memory[1:0]
- mem_wdata = srcB_memory replicated four times.
REQ-025 A vector access SHALL use four beats k = 0..3 with:
- mem_addr = ({vector_address_data_memory[11:2], 2'b00} + 4k), modulo 4096, wrapping past 0xFFC to 0x000
- mem_be = 4'hF
- mem_wdata = vector_data_memory[32k+31:32k].
REQ-026 A 2-bit beat counter SHALL clear in IDLE and increment on each completed beat.
REQ-027 At most one read SHALL be outstanding; mem_rvalid outside WAIT_RD SHALL be ignored.
REQ-028 Load data SHALL be registered as follows:
- scalar: the byte selected by address bits [1:0] of mem_rdata.
- vector: beat k into load_data_vector[32k+31:32k].
- Both outputs SHALL hold until the next load overwrites them.
REQ-029 load_valid SHALL be 1 exactly in DONE of a load.
REQ-030 With mem_ready=1 and mem_rvalid one cycle after accept, the latency from access present to DONE SHALL be:
- store: 2 cycles scalar / 5 cycles vector
- load: 3 cycles scalar / 9 cycles vector.

Reset
REQ-031 Reset assertion SHALL immediately force the following, including mid-transfer:
- state = IDLE, beat counter = 0
- mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_be = 0
- load_data_scalar = 0, load_data_vector = 0, load_valid = 0, mem_error = 0.
- stall_memory SHALL then follow REQ-022.
REQ-032 After reset release, a pending access SHALL restart from beat 0.

Configuration
REQ-033 With MEM_ACCESS_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles spent in REQ or WAIT_RD without a handshake.
- On reaching 255 it SHALL set mem_error, abort the access and go to DONE (load_valid = 0 for an aborted load).
- mem_error SHALL stay set until reset.
REQ-034 Without MEM_ACCESS_TIMEOUT_EN, mem_error SHALL be tied 0 and no watchdog logic SHALL exist.

Verification
REQ-035 Scalar store: ALUresult=0x0D, srcB=0xA5, mem_ready=1 -> one beat with mem_addr=0x00C, mem_be=4'b0010, mem_wdata=0xA5A5A5A5; stall high for 2 cycles.
REQ-036 Vector load: base=0xFF8, rdata per beat 0x11111111..0x44444444 -> addresses 0xFF8, 0xFFC, 0x000, 0x004; load_data_vector=0x44444444_33333333_22222222_11111111; load_valid pulses once.
REQ-037 Scalar load at byte 0x03 with mem_ready held low for 3 cycles -> mem_addr/mem_req stable throughout; load_data_scalar = mem_rdata[31:24].
REQ-038 Both request inputs = 1 -> store performed; load_valid stays 0.
REQ-039 Reset asserted during beat 2 of a vector store -> mem_req drops immediately; after release, the store restarts at beat 0.
REQ-040 MEM_ACCESS_TIMEOUT_EN defined, mem_ready=0 forever -> mem_error=1 after 255 cycles in REQ; FSM reaches DONE; stall releases.
